shreg_seq_shifter: RTL and testbench
====================================

Name: shreg_seq_shifter

Overview:
- Parametrised sequential shift engine; successor to the fixed 8-bit load/shift register.
- Accepts a word, a shift amount and a mode. Shifts the word by up to STEP positions per clock until the amount is exhausted, then pulses done.
- Sits behind simple control logic as a small-area multi-cycle alternative to a combinational barrel shifter.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- SH_W, $clog2(WIDTH), width of the shift-amount input; amounts range 0..2^SH_W-1, and amounts >= WIDTH are legal.
- STEP, 1, maximum positions shifted per clock (1..WIDTH-1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- load  in  1  start request; accepted only when ready=1.
- d_in  in  WIDTH  operand, captured on accept.
- sh  in  SH_W  shift amount, captured on accept.
- shift_r_l  in  1  direction: 1=right, 0=left; captured on accept.
- arith  in  1  1=arithmetic right (sign fill); ignored for left shifts; captured on accept.
- d_out  out  WIDTH  working register; holds the final result from done until the next accept.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT.
- done  out  1  single-cycle pulse; d_out is valid in this cycle.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, d_out=0, cnt=0, ready=1, busy=0, done=0. Reset wins over a simultaneous load. Reset during SHIFT or DONE aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE: on load=1, capture d_in into d_out, sh into cnt, and capture shift_r_l and arith.
  - If sh!=0, go to SHIFT.
  - If sh==0, go straight to DONE.
- SHIFT: each edge shifts d_out by k=min(STEP,cnt) and sets cnt-=k.
  - Left shift: zero fill.
  - Right logical shift: zero fill.
  - Right arithmetic shift: replicate the MSB captured at accept.
  - When the updated cnt==0, go to DONE.
- Shifts of WIDTH or more positions saturate: the result is all zeros, or all sign bits for arithmetic right.
- DONE: done=1 for exactly one cycle, d_out is stable, then return to IDLE unconditionally.
- Latency: done is high in the cycle starting ceil(sh/STEP)+1 edges after the accept edge. For sh=0 this is 1 edge.
- load while ready=0 is ignored and not queued. Changes to d_in, sh, shift_r_l or arith after accept have no effect.
- Back-to-back operation: the earliest next accept is the IDLE cycle following DONE.

Optional Feature:
- Macro: SHREG_ROTATE_EN.
- Defined: adds input port rot (1 bit, captured on accept). When rot=1, bits leaving one end re-enter the other end, in the direction given by shift_r_l.
  - arith is ignored while rot=1.
  - Amounts >= WIDTH are taken modulo WIDTH in effect; the engine still spends ceil(sh/STEP) SHIFT cycles.
  - rot=0 gives the base behaviour.
- Not defined: port rot is absent; only fill-type shifts exist.

Test Plan:
- Hold rst=0 for 2 edges, then release -> d_out=0x00, ready=1, busy=0, done=0. load=1 asserted during reset is not accepted.
- WIDTH=8, STEP=1; d_in=0xAA, sh=1, left -> busy for 1 cycle, done 2 edges after accept, d_out=0x54.
- d_in=0xEE, sh=2, right logical -> d_out=0x3B, done 3 edges after accept. Separately, d_in=0xAA, sh=3, right arith -> d_out=0xF5.
- d_in=0xAA, sh=0 -> done 1 edge after accept, d_out=0xAA. Pulsing load during busy of a sh=5 operation is ignored, and that operation's result is unchanged.
- STEP=4; d_in=0xAA, sh=5, left -> 2 SHIFT cycles (4 then 1), d_out=0x40. Separately, sh=7 right arith on 0x80 -> d_out=0xFF.
- Drop rst mid-SHIFT -> next cycle d_out=0, IDLE, no done pulse. With SHREG_ROTATE_EN: 0x81, sh=1, left, rot=1 -> 0x03; 0x81, sh=9, right, rot=1 -> 0xC0.

Source files
------------

// File: rtl/shreg_seq_shifter.sv
// shreg_seq_shifter: multi-cycle shift engine. It captures a word, a shift
// amount and a mode, shifts the word by up to STEP positions per clock until
// the amount is used up, and then pulses done for one cycle.
// Define SHREG_ROTATE_EN to add the rot input, which selects rotation in
// place of fill shifting.

module shreg_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH),
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SH_W-1:0]  sh,
  input  logic             shift_r_l,
  input  logic             arith,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // STEP is at most WIDTH-1, so it always fits in the amount width.
  localparam logic [SH_W-1:0] STEP_K = SH_W'(STEP);

  state_t          state;
  state_t          state_nxt;
  logic [SH_W-1:0] cnt;
  logic            dir_r;
  logic            arith_r;
  logic            sign_r;
  logic [SH_W-1:0] k;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;
`ifdef SHREG_ROTATE_EN
  localparam logic [SH_W:0] WIDTH_K = (SH_W+1)'(WIDTH);
  logic            rot_r;
  logic [SH_W:0]   rk;
`endif

  // Step size for this cycle and the word after shifting by that step.
  // A step of 0 makes the complementary rotate shift equal WIDTH, which
  // yields zero, so the rotate stays correct at k=0.
  always_comb begin
    k         = (cnt < STEP_K) ? cnt : STEP_K;
    fill_mask = ~({WIDTH{1'b1}} >> k);
    if (dir_r) begin
      shifted = d_out >> k;
      if (arith_r && sign_r) begin
        shifted = shifted | fill_mask;
      end
    end else begin
      shifted = d_out << k;
    end
`ifdef SHREG_ROTATE_EN
    rk = WIDTH_K - {1'b0, k};
    if (rot_r) begin
      if (dir_r) begin
        shifted = (d_out >> k) | (d_out << rk);
      end else begin
        shifted = (d_out << k) | (d_out >> rk);
      end
    end
`endif
  end

  // State register; a low rst at an edge wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for load, SHIFT runs until cnt is used up,
  // and DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = (sh == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == k) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the state register only.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == SHIFT);
    done  = (state == DONE);
  end

  // Datapath: capture the operands on accept, then step the word and count
  // down the remaining amount while shifting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_out   <= '0;
      cnt     <= '0;
      dir_r   <= 1'b0;
      arith_r <= 1'b0;
      sign_r  <= 1'b0;
`ifdef SHREG_ROTATE_EN
      rot_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            d_out   <= d_in;
            cnt     <= sh;
            dir_r   <= shift_r_l;
            arith_r <= arith;
            sign_r  <= d_in[WIDTH-1];
`ifdef SHREG_ROTATE_EN
            rot_r   <= rot;
`endif
          end
        end
        SHIFT: begin
          d_out <= shifted;
          cnt   <= cnt - k;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_seq_shifter.sv
// tb_shreg_seq_shifter: drives two shifter instances (STEP=1 and STEP=4)
// with the same operations. Each instance is compared cycle by cycle
// against a bit-index reference model and an expected latency.

module tb_shreg_seq_shifter;

  localparam int WIDTH  = 8;
  localparam int SH_W   = 4;
  localparam int STEP_A = 1;
  localparam int STEP_B = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic [SH_W-1:0]  sh = '0;
  logic             shift_r_l = 1'b0;
  logic             arith = 1'b0;
  logic             rot = 1'b0;
  logic [WIDTH-1:0] d_out_a, d_out_b;
  logic             ready_a, ready_b, busy_a, busy_b, done_a, done_b;

  int vectors = 0;
  int miscompares = 0;

  shreg_seq_shifter #(.WIDTH(WIDTH), .SH_W(SH_W), .STEP(STEP_A)) dut_a (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .sh(sh),
    .shift_r_l(shift_r_l), .arith(arith),
`ifdef SHREG_ROTATE_EN
    .rot(rot),
`endif
    .d_out(d_out_a), .ready(ready_a), .busy(busy_a), .done(done_a)
  );

  shreg_seq_shifter #(.WIDTH(WIDTH), .SH_W(SH_W), .STEP(STEP_B)) dut_b (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .sh(sh),
    .shift_r_l(shift_r_l), .arith(arith),
`ifdef SHREG_ROTATE_EN
    .rot(rot),
`endif
    .d_out(d_out_b), .ready(ready_b), .busy(busy_b), .done(done_b)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result computed per output bit from the source bit it takes.
  function automatic logic [WIDTH-1:0] refResult(input logic [WIDTH-1:0] d, input int s,
                                                 input bit right, input bit ar, input bit rt);
    logic [WIDTH-1:0] r;
    bit fill;
    int m;
    fill = right && ar && d[WIDTH-1];
    m = s % WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (rt) begin
        r[i] = right ? d[(i + m) % WIDTH] : d[(i - m + WIDTH) % WIDTH];
      end else if (right) begin
        r[i] = (i + s < WIDTH) ? d[i + s] : fill;
      end else begin
        r[i] = (i - s >= 0) ? d[i - s] : 1'b0;
      end
    end
    return r;
  endfunction

  // Number of edges from the accept edge to the edge that raises done.
  function automatic int refLatency(input int s, input int step);
    return (s == 0) ? 1 : (s + step - 1) / step + 1;
  endfunction

  // Runs one operation on both instances, starting and ending at a negedge
  // with both idle. Load is pulsed only while both are unable to accept,
  // and operands are scrambled after accept.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int s,
                               input bit right, input bit ar, input bit rt);
    logic [WIDTH-1:0] exp_v;
    bit rt_eff;
    int lat_a, lat_b, lo, hi;
`ifdef SHREG_ROTATE_EN
    rt_eff = rt;
`else
    rt_eff = 1'b0;
`endif
    exp_v = refResult(d, s, right, ar, rt_eff);
    lat_a = refLatency(s, STEP_A);
    lat_b = refLatency(s, STEP_B);
    lo = (lat_a < lat_b) ? lat_a : lat_b;
    hi = (lat_a > lat_b) ? lat_a : lat_b;
    load = 1'b1;
    d_in = d;
    sh = SH_W'(s);
    shift_r_l = right;
    arith = ar;
    rot = rt;
    @(posedge clk);
    for (int e = 1; e <= hi + 1; e++) begin
      @(negedge clk);
      load = (e <= lo) && ($urandom_range(0, 3) == 0);
      d_in = WIDTH'($urandom);
      sh = SH_W'($urandom);
      shift_r_l = 1'($urandom);
      arith = 1'($urandom);
      rot = 1'($urandom);
      checkOutput("done_a", 32'(done_a), 32'(e == lat_a));
      checkOutput("busy_a", 32'(busy_a), 32'(e < lat_a));
      checkOutput("ready_a", 32'(ready_a), 32'(e > lat_a));
      if (e == lat_a) checkOutput("d_out_a", 32'(d_out_a), 32'(exp_v));
      checkOutput("done_b", 32'(done_b), 32'(e == lat_b));
      checkOutput("busy_b", 32'(busy_b), 32'(e < lat_b));
      checkOutput("ready_b", 32'(ready_b), 32'(e > lat_b));
      if (e == lat_b) checkOutput("d_out_b", 32'(d_out_b), 32'(exp_v));
      if (e < hi + 1) @(posedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    // Reset held for two edges with load requested throughout.
    rst = 1'b0;
    load = 1'b1;
    d_in = 8'hAA;
    sh = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_d_out_a", 32'(d_out_a), 32'h00);
    checkOutput("rst_ready_a", 32'(ready_a), 32'h1);
    checkOutput("rst_busy_a", 32'(busy_a), 32'h0);
    checkOutput("rst_done_a", 32'(done_a), 32'h0);
    checkOutput("rst_d_out_b", 32'(d_out_b), 32'h00);
    checkOutput("rst_ready_b", 32'(ready_b), 32'h1);
    rst = 1'b1;
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_ready_a", 32'(ready_a), 32'h1);
    checkOutput("post_rst_d_out_a", 32'(d_out_a), 32'h00);

    // Directed operations.
    applyStimulus(8'hAA, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hEE, 2, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hAA, 3, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hAA, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hAA, 5, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 7, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h80, 15, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hFF, 12, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h81, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h81, 9, 1'b1, 1'b0, 1'b1);

    // Reset dropped two edges into a long operation: no done may follow.
    load = 1'b1;
    d_in = 8'h80;
    sh = 4'd15;
    shift_r_l = 1'b1;
    arith = 1'b1;
    rot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_d_out_a", 32'(d_out_a), 32'h00);
    checkOutput("abort_d_out_b", 32'(d_out_b), 32'h00);
    checkOutput("abort_ready_a", 32'(ready_a), 32'h1);
    checkOutput("abort_busy_a", 32'(busy_a), 32'h0);
    checkOutput("abort_done_a", 32'(done_a), 32'h0);
    checkOutput("abort_ready_b", 32'(ready_b), 32'h1);
    checkOutput("abort_busy_b", 32'(busy_b), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_no_done_a", 32'(done_a), 32'h0);
      checkOutput("abort_no_done_b", 32'(done_b), 32'h0);
    end

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(WIDTH'($urandom), $urandom_range(0, 15), 1'($urandom),
                    1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
